// File: rtl/ram_pkg.sv
// Shared definitions for the byte-writable data memory and the load/store unit:
// read-during-write mode constants, the clear/ready state type and the byte merge.
package ram_pkg;

    // Same-address read-during-write behaviour
    localparam int RDW_OLD = 0;
    localparam int RDW_NEW = 1;

    // byte_merge works on a fixed maximum width; callers zero-extend their
    // operands and truncate the result back to their own word width.
    localparam int MERGE_MAX_W  = 1024;
    localparam int MERGE_MAX_BE = MERGE_MAX_W / 8;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } ram_state_t;

    // Take byte k from new_word where byte_en[k] is set, otherwise from old_word
    function automatic logic [MERGE_MAX_W-1:0] byte_merge(
        input logic [MERGE_MAX_W-1:0]  old_word,
        input logic [MERGE_MAX_W-1:0]  new_word,
        input logic [MERGE_MAX_BE-1:0] byte_en
    );
        logic [MERGE_MAX_W-1:0] merged;
        merged = old_word;
        for (int k = 0; k < MERGE_MAX_BE; k++) begin
            if (byte_en[k]) begin
                merged[8*k +: 8] = new_word[8*k +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/ram_clear_sequencer.sv
// Post-reset clear sequencer: walks a counter over every word, requesting a
// zero write each cycle, then parks in READY. Reset restarts it at word 0.
module ram_clear_sequencer
    import ram_pkg::*;
#(
    parameter int CNT_W          = 12,
    parameter int DEPTH          = 4096,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic             clk,
    input  logic             reset,
    output logic             busy,
    output logic             clrEn,
    output logic [CNT_W-1:0] clrAddr
);

    localparam logic [CNT_W-1:0] LAST_ADDR   = CNT_W'(DEPTH - 1);
    localparam ram_state_t       RESET_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : READY;

    ram_state_t       r_state;
    ram_state_t       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    // State and clear-address counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= RESET_STATE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next state, counter advance and clear-port outputs; reset overrides outputs
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        busy        = 1'b0;
        clrEn       = 1'b0;
        clrAddr     = r_cnt;
        case (r_state)
            CLEAR: begin
                busy  = 1'b1;
                clrEn = 1'b1;
                if (r_cnt == LAST_ADDR) begin
                    w_state_nxt = READY;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            READY: begin
                w_state_nxt = READY;
            end
            default: begin
                w_state_nxt = RESET_STATE;
            end
        endcase
        if (reset) begin
            busy  = (CLEAR_ON_RESET != 0);
            clrEn = 1'b0;
        end
    end

endmodule

// File: rtl/ram_bytewise_dp.sv
// Simple dual-port data memory: byte-enabled write port, independent read port
// with valid strobe, 1- or 2-cycle read latency, selectable read-during-write
// behaviour, out-of-range address flagging and an optional post-reset clear.
module ram_bytewise_dp
    import ram_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDRESS_WIDTH  = 12,
    parameter int DEPTH          = 4096,
    parameter int READ_LATENCY   = 1,
    parameter int RDW_MODE       = RDW_OLD,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wEn,
    input  logic [ADDRESS_WIDTH-1:0] wAddr,
    input  logic [DATA_WIDTH/8-1:0]  byteEn,
    input  logic [DATA_WIDTH-1:0]    dataIn,
    input  logic                     rEn,
    input  logic [ADDRESS_WIDTH-1:0] rAddr,
    output logic [DATA_WIDTH-1:0]    dataOut,
    output logic                     rValid,
    output logic                     busy,
    output logic                     addrErr
);

    localparam int                   BE_W      = DATA_WIDTH / 8;
    localparam int                   IDX_W     = $clog2(DEPTH);
    localparam logic [ADDRESS_WIDTH:0] DEPTH_EXT = (ADDRESS_WIDTH + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic                  w_busy;
    logic                  w_clr_en;
    logic [IDX_W-1:0]      w_clr_addr;

    logic                  w_wr_acc;
    logic                  w_rd_acc;
    logic                  w_wr_ok;
    logic                  w_rd_ok;

    logic                  w_mem_we;
    logic [IDX_W-1:0]      w_mem_idx;
    logic [BE_W-1:0]       w_mem_be;
    logic [DATA_WIDTH-1:0] w_mem_din;

    logic [IDX_W-1:0]      w_rd_idx;
    logic [DATA_WIDTH-1:0] w_rd_word;

    logic                  r_vld_p0;
    logic                  r_err_p0;
    logic [DATA_WIDTH-1:0] r_rdata_p0;
    logic                  w_vld_out;
    logic [DATA_WIDTH-1:0] w_data_out;

    ram_clear_sequencer #(
        .CNT_W          (IDX_W),
        .DEPTH          (DEPTH),
        .CLEAR_ON_RESET (CLEAR_ON_RESET)
    ) u_clear (
        .clk     (clk),
        .reset   (reset),
        .busy    (w_busy),
        .clrEn   (w_clr_en),
        .clrAddr (w_clr_addr)
    );

    // Requests are only taken in READY outside reset; *_ok adds the range check
    assign w_wr_acc = wEn & ~w_busy & ~reset;
    assign w_rd_acc = rEn & ~w_busy & ~reset;
    assign w_wr_ok  = w_wr_acc & ({1'b0, wAddr} < DEPTH_EXT);
    assign w_rd_ok  = w_rd_acc & ({1'b0, rAddr} < DEPTH_EXT);
    assign w_rd_idx = rAddr[IDX_W-1:0];

    // Write-port mux: clear sequencer owns the port while it runs
    always_comb begin
        w_mem_we  = 1'b0;
        w_mem_idx = wAddr[IDX_W-1:0];
        w_mem_be  = byteEn;
        w_mem_din = dataIn;
        if (w_clr_en) begin
            w_mem_we  = 1'b1;
            w_mem_idx = w_clr_addr;
            w_mem_be  = '1;
            w_mem_din = '0;
        end else if (w_wr_ok) begin
            w_mem_we  = 1'b1;
        end
    end

    // Array write with per-byte enables
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int b = 0; b < BE_W; b++) begin
                if (w_mem_be[b]) begin
                    r_mem[w_mem_idx][8*b +: 8] <= w_mem_din[8*b +: 8];
                end
            end
        end
    end

    // Read word selection: zero for out-of-range, merged bypass on same-address write
    always_comb begin
        w_rd_word = '0;
        if (w_rd_ok) begin
            w_rd_word = r_mem[w_rd_idx];
            if ((RDW_MODE == RDW_NEW) && w_wr_ok && (wAddr == rAddr)) begin
                w_rd_word = DATA_WIDTH'(byte_merge(MERGE_MAX_W'(r_mem[w_rd_idx]),
                                                   MERGE_MAX_W'(dataIn),
                                                   MERGE_MAX_BE'(byteEn)));
            end
        end
    end

    // ---- Stage p0: registered array read, valid and address-error flag ----
    // Data only reloads on an accepted read so dataOut holds between results
    always_ff @(posedge clk) begin
        if (reset) begin
            r_vld_p0   <= 1'b0;
            r_err_p0   <= 1'b0;
            r_rdata_p0 <= '0;
        end else begin
            r_vld_p0 <= w_rd_acc;
            r_err_p0 <= (w_wr_acc & ~w_wr_ok) | (w_rd_acc & ~w_rd_ok);
            if (w_rd_acc) begin
                r_rdata_p0 <= w_rd_word;
            end
        end
    end

    // ---- Stage p1: optional output register for two-cycle read latency ----
    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic                  r_vld_p1;
            logic [DATA_WIDTH-1:0] r_rdata_p1;

            // Second pipeline register, reloaded only when stage p0 carries a result
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_vld_p1   <= 1'b0;
                    r_rdata_p1 <= '0;
                end else begin
                    r_vld_p1 <= r_vld_p0;
                    if (r_vld_p0) begin
                        r_rdata_p1 <= r_rdata_p0;
                    end
                end
            end

            assign w_vld_out  = r_vld_p1;
            assign w_data_out = r_rdata_p1;
        end else begin : g_lat1
            assign w_vld_out  = r_vld_p0;
            assign w_data_out = r_rdata_p0;
        end
    endgenerate

    // Outputs are forced quiet for the whole time reset is high, including the
    // first cycle before the registers have been flushed
    assign rValid  = w_vld_out & ~reset;
    assign dataOut = reset ? '0 : w_data_out;
    assign addrErr = r_err_p0 & ~reset;
    assign busy    = w_busy;

endmodule

// File: tb/tb_ram_bytewise_dp.sv
// Bench for ram_bytewise_dp: two instances share one stimulus stream
//   A: DEPTH=16,  READ_LATENCY=1, RDW_MODE=0
//   B: DEPTH=100, READ_LATENCY=2, RDW_MODE=1
// A behavioural model (word arrays, clear countdown, latency delay line)
// predicts every output of both instances.
module tb_ram_bytewise_dp;

    localparam int AW = 8;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          wEn = 1'b0;
    logic [AW-1:0] wAddr = '0;
    logic [3:0]    byteEn = '0;
    logic [DW-1:0] dataIn = '0;
    logic          rEn = 1'b0;
    logic [AW-1:0] rAddr = '0;

    logic [DW-1:0] dout_a, dout_b;
    logic          vld_a, vld_b, busy_a, busy_b, err_a, err_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ram_bytewise_dp #(
        .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .DEPTH(16),
        .READ_LATENCY(1), .RDW_MODE(0), .CLEAR_ON_RESET(1)
    ) dut_a (
        .clk(clk), .reset(reset), .wEn(wEn), .wAddr(wAddr), .byteEn(byteEn),
        .dataIn(dataIn), .rEn(rEn), .rAddr(rAddr), .dataOut(dout_a),
        .rValid(vld_a), .busy(busy_a), .addrErr(err_a)
    );

    ram_bytewise_dp #(
        .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .DEPTH(100),
        .READ_LATENCY(2), .RDW_MODE(1), .CLEAR_ON_RESET(1)
    ) dut_b (
        .clk(clk), .reset(reset), .wEn(wEn), .wAddr(wAddr), .byteEn(byteEn),
        .dataIn(dataIn), .rEn(rEn), .rAddr(rAddr), .dataOut(dout_b),
        .rValid(vld_b), .busy(busy_b), .addrErr(err_b)
    );

    // ---------------- reference model ----------------
    logic [DW-1:0] mem [2][128];
    int            busy_left [2];
    logic          prev_v [2];
    logic [DW-1:0] prev_d [2];
    logic          exp_v [2];
    logic [DW-1:0] exp_d [2];
    logic          exp_e [2];
    logic          exp_busy [2];

    function automatic int dep(int d);  return (d == 0) ? 16 : 100; endfunction
    function automatic int lat(int d);  return (d == 0) ? 1 : 2;    endfunction
    function automatic int rdw(int d);  return (d == 0) ? 0 : 1;    endfunction

    function automatic logic [DW-1:0] merge(logic [DW-1:0] o, logic [DW-1:0] n, logic [3:0] be);
        logic [DW-1:0] m;
        m = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        return (o & ~m) | (n & m);
    endfunction

    function automatic void model_edge(int d);
        logic          busy_now, acc_w, acc_r, w_in, r_in, nv;
        logic [DW-1:0] rd, nd;
        if (reset) begin
            busy_left[d] = dep(d);
            prev_v[d] = 1'b0; prev_d[d] = '0;
            exp_v[d]  = 1'b0; exp_d[d]  = '0;
            exp_e[d]  = 1'b0; exp_busy[d] = 1'b1;
            return;
        end
        busy_now = (busy_left[d] != 0);
        acc_w = wEn && !busy_now;
        acc_r = rEn && !busy_now;
        w_in  = int'(wAddr) < dep(d);
        r_in  = int'(rAddr) < dep(d);
        rd = '0;
        if (acc_r && r_in) begin
            rd = mem[d][rAddr];
            if (rdw(d) == 1 && acc_w && w_in && wAddr == rAddr) rd = merge(rd, dataIn, byteEn);
        end
        if (acc_w && w_in) mem[d][wAddr] = merge(mem[d][wAddr], dataIn, byteEn);
        if (busy_now) begin
            busy_left[d]--;
            if (busy_left[d] == 0) for (int k = 0; k < 128; k++) mem[d][k] = '0;
        end
        exp_e[d] = (acc_w && !w_in) || (acc_r && !r_in);
        if (lat(d) == 1) begin
            nv = acc_r; nd = rd;
        end else begin
            nv = prev_v[d]; nd = prev_d[d];
            prev_v[d] = acc_r; prev_d[d] = rd;
        end
        exp_v[d] = nv;
        if (nv) exp_d[d] = nd;
        exp_busy[d] = (busy_left[d] != 0);
    endfunction

    function automatic logic [DW-1:0] get_d(int d); return (d == 0) ? dout_a : dout_b; endfunction
    function automatic logic get_v(int d); return (d == 0) ? vld_a  : vld_b;  endfunction
    function automatic logic get_e(int d); return (d == 0) ? err_a  : err_b;  endfunction
    function automatic logic get_b(int d); return (d == 0) ? busy_a : busy_b; endfunction

    // One clock edge: model follows the inputs seen at the edge, outputs settle by +1
    task automatic tick();
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        #1;
    endtask

    task automatic idle_inputs();
        wEn = 1'b0; rEn = 1'b0; byteEn = '0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_checks++;
            if ({busy_a, busy_b, vld_a, vld_b, err_a, err_b} !== 6'b110000) begin
                n_fail++;
                $display("FAIL reset_flags: got %b want 110000", {busy_a, busy_b, vld_a, vld_b, err_a, err_b});
            end
            n_checks++;
            if (dout_a !== 32'h0 || dout_b !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_data: got a=%h b=%h want 0", dout_a, dout_b);
            end
        end
    endtask

    task automatic test_clear();
        int   cnt_a, cnt_b;
        logic pre_a, pre_b;
        reset = 1'b0; wEn = 1'b0; rEn = 1'b1;
        #1;
        cnt_a = busy_a ? 1 : 0;
        cnt_b = busy_b ? 1 : 0;
        for (int c = 0; c < 300; c++) begin
            if (!busy_a && !busy_b) break;
            pre_a = busy_a; pre_b = busy_b;
            rAddr = 8'($urandom_range(0, 127));
            tick();
            if (pre_a) begin
                n_checks++;
                if (vld_a !== 1'b0 || err_a !== 1'b0) begin
                    n_fail++;
                    $display("FAIL clear_quiet_a: got vld=%b err=%b want 0 0", vld_a, err_a);
                end
            end
            if (pre_b) begin
                n_checks++;
                if (vld_b !== 1'b0 || err_b !== 1'b0) begin
                    n_fail++;
                    $display("FAIL clear_quiet_b: got vld=%b err=%b want 0 0", vld_b, err_b);
                end
            end
            if (busy_a) cnt_a++;
            if (busy_b) cnt_b++;
        end
        n_checks++;
        if (busy_a || busy_b) begin
            n_fail++;
            $display("FAIL clear_timeout: busy a=%b b=%b still high", busy_a, busy_b);
        end
        n_checks++;
        if (cnt_a != 16 || cnt_b != 100) begin
            n_fail++;
            $display("FAIL clear_len: got a=%0d b=%0d want 16 100", cnt_a, cnt_b);
        end
        idle_inputs();
        tick();
        // every word of A reads back zero, streamed
        for (int t = 0; t <= 16; t++) begin
            rEn = (t < 16); rAddr = 8'(t);
            tick();
            if (t < 16) begin
                n_checks++;
                if (vld_a !== 1'b1 || dout_a !== 32'h0) begin
                    n_fail++;
                    $display("FAIL clear_read_a[%0d]: got vld=%b data=%h want 1 0", t, vld_a, dout_a);
                end
            end
            if (t >= 1) begin
                n_checks++;
                if (vld_b !== 1'b1 || dout_b !== 32'h0) begin
                    n_fail++;
                    $display("FAIL clear_read_b[%0d]: got vld=%b data=%h want 1 0", t - 1, vld_b, dout_b);
                end
            end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_byte_write();
        wEn = 1'b1; wAddr = 8'd5; byteEn = 4'b1111; dataIn = 32'hAABBCCDD;
        tick();
        byteEn = 4'b0101; dataIn = 32'h11223344;
        tick();
        idle_inputs(); rEn = 1'b1; rAddr = 8'd5;
        tick();
        n_checks++;
        if (vld_a !== 1'b1 || dout_a !== 32'hAA22CC44 || vld_b !== 1'b0) begin
            n_fail++;
            $display("FAIL byte_write_lat1: got vld_a=%b a=%h vld_b=%b want 1 aa22cc44 0", vld_a, dout_a, vld_b);
        end
        idle_inputs();
        tick();
        n_checks++;
        if (vld_b !== 1'b1 || dout_b !== 32'hAA22CC44 || vld_a !== 1'b0) begin
            n_fail++;
            $display("FAIL byte_write_lat2: got vld_b=%b b=%h vld_a=%b want 1 aa22cc44 0", vld_b, dout_b, vld_a);
        end
    endtask

    task automatic test_rdw();
        wEn = 1'b1; wAddr = 8'd7; byteEn = 4'b0011; dataIn = 32'hFFFFFFFF;
        rEn = 1'b1; rAddr = 8'd7;
        tick();
        n_checks++;
        if (vld_a !== 1'b1 || dout_a !== 32'h00000000) begin
            n_fail++;
            $display("FAIL rdw_old: got vld=%b data=%h want 1 00000000", vld_a, dout_a);
        end
        idle_inputs();
        tick();
        n_checks++;
        if (vld_b !== 1'b1 || dout_b !== 32'h0000FFFF) begin
            n_fail++;
            $display("FAIL rdw_new: got vld=%b data=%h want 1 0000ffff", vld_b, dout_b);
        end
        rEn = 1'b1; rAddr = 8'd7;
        tick();
        idle_inputs();
        n_checks++;
        if (dout_a !== 32'h0000FFFF) begin
            n_fail++;
            $display("FAIL rdw_after_a: got %h want 0000ffff", dout_a);
        end
        tick();
        n_checks++;
        if (dout_b !== 32'h0000FFFF) begin
            n_fail++;
            $display("FAIL rdw_after_b: got %h want 0000ffff", dout_b);
        end
    endtask

    task automatic test_back_to_back();
        int run_a, run_b;
        run_a = 0; run_b = 0;
        for (int i = 0; i < 10; i++) begin
            wEn = 1'b1; wAddr = 8'(i); byteEn = 4'hF; dataIn = 32'hA55A0000 + 32'(i);
            tick();
        end
        idle_inputs();
        for (int t = 0; t <= 10; t++) begin
            rEn = (t < 10); rAddr = 8'(t);
            tick();
            if (vld_a) run_a++;
            if (vld_b) run_b++;
            if (t < 10) begin
                n_checks++;
                if (vld_a !== 1'b1 || dout_a !== 32'hA55A0000 + 32'(t)) begin
                    n_fail++;
                    $display("FAIL stream_a[%0d]: got vld=%b data=%h want 1 %h", t, vld_a, dout_a, 32'hA55A0000 + 32'(t));
                end
            end
            if (t >= 1) begin
                n_checks++;
                if (vld_b !== 1'b1 || dout_b !== 32'hA55A0000 + 32'(t - 1)) begin
                    n_fail++;
                    $display("FAIL stream_b[%0d]: got vld=%b data=%h want 1 %h", t - 1, vld_b, dout_b, 32'hA55A0000 + 32'(t - 1));
                end
            end
        end
        idle_inputs();
        tick();
        if (vld_b) run_b++;
        n_checks++;
        if (run_a != 10 || run_b != 10) begin
            n_fail++;
            $display("FAIL stream_count: got a=%0d b=%0d want 10 10", run_a, run_b);
        end
    endtask

    task automatic test_boundary();
        logic [DW-1:0] keep;
        keep = 32'h99887766;
        wEn = 1'b1; wAddr = 8'd99; byteEn = 4'hF; dataIn = keep;
        tick();
        idle_inputs();
        tick();
        wEn = 1'b1; wAddr = 8'd100; byteEn = 4'hF; dataIn = $urandom;
        rEn = 1'b1; rAddr = 8'd120;
        tick();
        idle_inputs();
        n_checks++;
        if (err_a !== 1'b1 || err_b !== 1'b1) begin
            n_fail++;
            $display("FAIL oor_err: got a=%b b=%b want 1 1", err_a, err_b);
        end
        n_checks++;
        if (vld_a !== 1'b1 || dout_a !== 32'h0) begin
            n_fail++;
            $display("FAIL oor_read_a: got vld=%b data=%h want 1 0", vld_a, dout_a);
        end
        tick();
        n_checks++;
        if (err_a !== 1'b0 || err_b !== 1'b0) begin
            n_fail++;
            $display("FAIL oor_pulse: got a=%b b=%b want 0 0", err_a, err_b);
        end
        n_checks++;
        if (vld_b !== 1'b1 || dout_b !== 32'h0) begin
            n_fail++;
            $display("FAIL oor_read_b: got vld=%b data=%h want 1 0", vld_b, dout_b);
        end
        rEn = 1'b1; rAddr = 8'd99;
        tick();
        idle_inputs();
        tick();
        n_checks++;
        if (vld_b !== 1'b1 || dout_b !== keep) begin
            n_fail++;
            $display("FAIL oor_word99: got vld=%b data=%h want 1 %h", vld_b, dout_b, keep);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            wEn    = ($urandom_range(0, 1) == 1);
            wAddr  = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(0, 127));
            byteEn = 4'($urandom_range(0, 15));
            dataIn = $urandom;
            rEn    = ($urandom_range(0, 3) != 0);
            rAddr  = ($urandom_range(0, 3) == 0) ? wAddr :
                     ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(0, 127));
            tick();
            for (int d = 0; d < 2; d++) begin
                n_checks++;
                if (get_v(d) !== exp_v[d] || get_d(d) !== exp_d[d]) begin
                    n_fail++;
                    $display("FAIL rand_read dut%0d cyc%0d: got vld=%b data=%h want %b %h", d, c, get_v(d), get_d(d), exp_v[d], exp_d[d]);
                end
                n_checks++;
                if (get_e(d) !== exp_e[d] || get_b(d) !== exp_busy[d]) begin
                    n_fail++;
                    $display("FAIL rand_flags dut%0d cyc%0d: got err=%b busy=%b want %b %b", d, c, get_e(d), get_b(d), exp_e[d], exp_busy[d]);
                end
            end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_reset_mid_clear();
        int   cnt_a;
        logic pre_a;
        // read in flight when reset rises
        rEn = 1'b1; rAddr = 8'd3;
        tick();
        idle_inputs();
        reset = 1'b1;
        #1;
        n_checks++;
        if (vld_a !== 1'b0) begin
            n_fail++;
            $display("FAIL inflight_a: got vld=%b want 0", vld_a);
        end
        tick();
        n_checks++;
        if (vld_b !== 1'b0) begin
            n_fail++;
            $display("FAIL inflight_b: got vld=%b want 0", vld_b);
        end
        reset = 1'b0;
        for (int c = 0; c < 9; c++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0; rEn = 1'b1;
        #1;
        cnt_a = busy_a ? 1 : 0;
        for (int c = 0; c < 40; c++) begin
            if (!busy_a) break;
            pre_a = busy_a;
            rAddr = 8'($urandom_range(0, 15));
            tick();
            if (pre_a) begin
                n_checks++;
                if (vld_a !== 1'b0) begin
                    n_fail++;
                    $display("FAIL midclear_vld: got %b want 0", vld_a);
                end
            end
            if (busy_a) cnt_a++;
        end
        n_checks++;
        if (cnt_a != 16) begin
            n_fail++;
            $display("FAIL midclear_len: got %0d want 16", cnt_a);
        end
        idle_inputs();
        for (int c = 0; c < 200; c++) begin
            if (!busy_b) break;
            tick();
        end
        n_checks++;
        if (busy_b !== 1'b0) begin
            n_fail++;
            $display("FAIL midclear_timeout_b: busy=%b want 0", busy_b);
        end
        rEn = 1'b1; rAddr = 8'd5;
        tick();
        idle_inputs();
        tick();
        n_checks++;
        if (vld_b !== 1'b1 || dout_b !== 32'h0 || dout_a !== 32'h0) begin
            n_fail++;
            $display("FAIL midclear_zero: got vld_b=%b b=%h a=%h want 1 0 0", vld_b, dout_b, dout_a);
        end
    endtask

    initial begin
        test_reset();
        test_clear();
        test_byte_write();
        test_rdw();
        test_back_to_back();
        test_boundary();
        test_random();
        test_reset_mid_clear();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
